// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared constants and FSM encoding for the cache block fill controller
package cache_fill_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_WPB     = 8;
    localparam int DEF_MEM_LAT = 4;
    localparam int DEF_NUM_CH  = 2;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/cache_fill_latpipe.sv
// rtl/cache_fill_latpipe.sv - fixed-depth valid/index token pipe matching the memory read latency
module cache_fill_latpipe
    import cache_fill_pkg::*;
#(
    parameter int LAT = DEF_MEM_LAT,
    parameter int IW  = $clog2(DEF_WPB)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);

    logic [LAT-1:0] vld;
    logic [IW-1:0]  idx [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_idx   = idx[LAT-1];

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - round-robin block fill engine: issues one block of pipelined reads per miss
module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WPB     = DEF_WPB,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int NUM_CH  = DEF_NUM_CH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          miss_req,
    input  logic [NUM_CH*ADDR_W-1:0]   miss_addr,
    output logic [NUM_CH-1:0]          fill_busy,
    output logic [NUM_CH-1:0]          fill_we,
    output logic [$clog2(WPB)-1:0]     fill_idx,
    output logic [DATA_W-1:0]          fill_data,
    output logic [NUM_CH-1:0]          fill_done,
    output logic                       mem_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int LW  = $clog2(WPB);
    localparam int OFF = LW + 1;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [LW:0]       LAST_CNT = (LW+1)'(WPB - 1);
    localparam logic [LW:0]       CNT_ONE  = (LW+1)'(1);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFF) - 1);

    state_t            state;
    logic [CW-1:0]     owner;
    logic [CW-1:0]     last_granted;
    logic [CW-1:0]     grant_ch;
    logic              grant_found;
    logic [ADDR_W-1:0] base_q;
    logic [LW:0]       issue_cnt;
    logic [LW:0]       ret_cnt;
    logic              pipe_valid;
    logic [LW-1:0]     pipe_idx;
    logic              last_ret;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        int c;
        c           = 0;
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (int'(last_granted) + i) % NUM_CH;
            if (!grant_found && miss_req[c]) begin
                grant_found = 1'b1;
                grant_ch    = CW'(c);
            end
        end
    end

    assign last_ret = pipe_valid && (ret_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            owner        <= '0;
            last_granted <= CW'(NUM_CH - 1);
            base_q       <= '0;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        state        <= S_ISSUE;
                        owner        <= grant_ch;
                        last_granted <= grant_ch;
                        base_q       <= miss_addr[int'(grant_ch)*ADDR_W +: ADDR_W] & ~LOW_MASK;
                        issue_cnt    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (issue_cnt == LAST_CNT) begin
                        state     <= S_DRAIN;
                        issue_cnt <= '0;
                    end else begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (last_ret) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (pipe_valid) begin
                ret_cnt <= last_ret ? '0 : ret_cnt + CNT_ONE;
            end
        end
    end

    cache_fill_latpipe #(
        .LAT (MEM_LAT),
        .IW  (LW)
    ) u_latpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mem_en),
        .in_idx    (issue_cnt[LW-1:0]),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    // Base has its offset bits cleared, so OR-ing the word offset never carries out of the block.
    assign mem_en    = (state == S_ISSUE);
    assign mem_addr  = mem_en ? (base_q | ADDR_W'({issue_cnt[LW-1:0], 1'b0})) : '0;
    assign fill_idx  = pipe_valid ? pipe_idx : '0;
    assign fill_data = pipe_valid ? mem_rdata : '0;

    always_comb begin
        fill_we   = '0;
        fill_done = '0;
        fill_busy = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fill_we[k]   = pipe_valid && (owner == CW'(k));
            fill_done[k] = (state == S_DONE) && (owner == CW'(k));
            fill_busy[k] = miss_req[k] || ((state != S_IDLE) && (owner == CW'(k)));
        end
    end

endmodule
